// File: rtl/fifo_rd_scheduler.sv
// fifo_rd_scheduler
// Drains NUM_CH FIFOs one after another, BURST_LEN words each, whenever a
// column block is flagged ready. Consecutive channel bursts can be separated
// by GAP_CYC idle cycles. Reads stall while the selected FIFO is empty, so each
// channel always receives exactly BURST_LEN reads.
//
// Optional feature macro: FIFO_RD_OVERRUN_EN
//   defined   -> overrun latches a rising edge of flag_cols seen while busy
//   undefined -> overrun is tied low and no edge-detect register exists
//
// State  | meaning
// IDLE   | waiting for flag_cols
// READ   | issuing reads on channel ch_sel, stalling on empty
// GAP    | GAP_CYC idle cycles between two channel bursts
// DONE   | single-cycle completion pulse, then back to IDLE

module fifo_rd_scheduler #(
    parameter int NUM_CH    = 2,
    parameter int BURST_LEN = 552,
    parameter int GAP_CYC   = 0,
    parameter int CNT_W     = 10
) (
    input  logic                                          fifo_rd_clk,
    input  logic                                          rst_n,
    input  logic                                          flag_cols,
    input  logic [NUM_CH-1:0]                             fifo_empty,
    output logic [NUM_CH-1:0]                             fifo_rd_en,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] ch_sel,
    output logic                                          busy,
    output logic                                          done,
    output logic                                          overrun
);

    localparam int                CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CNT_W-1:0]  BURST_LD = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0]  GAP_LD   = CNT_W'(GAP_CYC);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CH_W-1:0]   LAST_CH  = CH_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t             state_q;
    logic [CH_W-1:0]    ch_q;
    logic [CNT_W-1:0]   word_cnt_q;
    logic [CNT_W-1:0]   gap_cnt_q;
    logic               busy_q;
    logic               done_q;

    logic [NUM_CH-1:0]  rd_en_d;
    logic               cur_empty_d;
    logic               rd_fire_d;

    // Read enable of the selected channel follows its empty flag while in READ;
    // the channel mux is written as a compare loop so ch_q never indexes past NUM_CH.
    always_comb begin
        rd_en_d     = '0;
        cur_empty_d = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_q == CH_W'(i)) begin
                cur_empty_d = fifo_empty[i];
                if (state_q == ST_READ) begin
                    rd_en_d[i] = !fifo_empty[i];
                end
            end
        end
        rd_fire_d = (state_q == ST_READ) && !cur_empty_d;
    end

    // Sequencing FSM with word / gap down-counters and registered status outputs.
    always_ff @(posedge fifo_rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ch_q       <= '0;
            word_cnt_q <= '0;
            gap_cnt_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (flag_cols) begin
                        state_q    <= ST_READ;
                        ch_q       <= '0;
                        word_cnt_q <= BURST_LD;
                        busy_q     <= 1'b1;
                    end
                end

                ST_READ: begin
                    if (rd_fire_d) begin
                        if (word_cnt_q <= CNT_ONE) begin
                            if (ch_q != LAST_CH) begin
                                ch_q       <= ch_q + CH_W'(1);
                                word_cnt_q <= BURST_LD;
                                if (GAP_CYC == 0) begin
                                    state_q <= ST_READ;
                                end else begin
                                    state_q   <= ST_GAP;
                                    gap_cnt_q <= GAP_LD;
                                end
                            end else begin
                                // Last word of the last channel: counter parks at 0
                                // outside READ so it never wraps inside READ.
                                state_q    <= ST_DONE;
                                word_cnt_q <= '0;
                                done_q     <= 1'b1;
                            end
                        end else begin
                            word_cnt_q <= word_cnt_q - CNT_ONE;
                        end
                    end
                end

                ST_GAP: begin
                    if (gap_cnt_q <= CNT_ONE) begin
                        state_q   <= ST_READ;
                        gap_cnt_q <= '0;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - CNT_ONE;
                    end
                end

                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end

                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_rd_en = rd_en_d;
    assign ch_sel     = ch_q;
    assign busy       = busy_q;
    assign done       = done_q;

`ifdef FIFO_RD_OVERRUN_EN
    logic flag_q;
    logic overrun_q;

    // A new trigger edge arriving while a sequence is running is latched until reset.
    always_ff @(posedge fifo_rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            flag_q <= flag_cols;
            if (flag_cols && !flag_q && busy_q) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign overrun = overrun_q;
`else
    assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rd_scheduler.sv
// Scoreboard bench for fifo_rd_scheduler: stimulus pushes expected read/done
// events (cycle, rd_en, ch_sel, done); per-DUT monitors pop and compare them.
// dut_a: NUM_CH=2, BURST_LEN=4, GAP_CYC=2. dut_b: NUM_CH=1, BURST_LEN=552, GAP_CYC=0.

module tb_fifo_rd_scheduler;

    typedef struct {
        int         cyc;
        logic [1:0] rd_en;
        logic       ch;
        logic       dn;
    } ev_t;

`ifdef FIFO_RD_OVERRUN_EN
    localparam logic OVR_EXP = 1'b1;
`else
    localparam logic OVR_EXP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flag_a, flag_b;
    logic [1:0] empty_a;
    logic [0:0] empty_b;
    logic [1:0] rd_en_a;
    logic [0:0] rd_en_b;
    logic [0:0] ch_sel_a, ch_sel_b;
    logic       busy_a, busy_b, done_a, done_b, ovr_a, ovr_b;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int rd0_cnt = 0;
    int rd1_cnt = 0;
    ev_t exp_a[$];
    ev_t exp_b[$];
    ev_t cur_a, cur_b;

    fifo_rd_scheduler #(.NUM_CH(2), .BURST_LEN(4), .GAP_CYC(2), .CNT_W(10)) dut_a (
        .fifo_rd_clk(clk), .rst_n(rst_n), .flag_cols(flag_a), .fifo_empty(empty_a),
        .fifo_rd_en(rd_en_a), .ch_sel(ch_sel_a), .busy(busy_a), .done(done_a),
        .overrun(ovr_a)
    );

    fifo_rd_scheduler #(.NUM_CH(1), .BURST_LEN(552), .GAP_CYC(0), .CNT_W(10)) dut_b (
        .fifo_rd_clk(clk), .rst_n(rst_n), .flag_cols(flag_b), .fifo_empty(empty_b),
        .fifo_rd_en(rd_en_b), .ch_sel(ch_sel_b), .busy(busy_b), .done(done_b),
        .overrun(ovr_b)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic wait_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input int c, input logic [1:0] en, input logic ch, input logic dn);
        ev_t e;
        e.cyc = c; e.rd_en = en; e.ch = ch; e.dn = dn;
        exp_a.push_back(e);
    endtask

    // One full dut_a sequence triggered in cycle base with FIFOs never empty.
    task automatic push_seq_a(input int base);
        for (int i = 1; i <= 4; i++) push_a(base + i, 2'b01, 1'b0, 1'b0);
        for (int i = 7; i <= 10; i++) push_a(base + i, 2'b10, 1'b1, 1'b0);
        push_a(base + 11, 2'b00, 1'b1, 1'b1);
    endtask

    // Monitor for dut_a: one-hot check every cycle, scoreboard pop on any output activity.
    always @(negedge clk) begin
        n_cmp++;
        if ($countones(rd_en_a) > 1) begin
            n_bad++;
            $display("FAIL onehot_a: rd_en=%b at cycle %0d", rd_en_a, cyc);
        end
        if (rd_en_a != 2'b00 || done_a) begin
            if (rd_en_a[0]) rd0_cnt++;
            if (rd_en_a[1]) rd1_cnt++;
            n_cmp++;
            if (exp_a.size() == 0) begin
                n_bad++;
                $display("FAIL mon_a unexpected: cyc=%0d rd_en=%b ch=%0d done=%b, expected no activity",
                         cyc, rd_en_a, ch_sel_a, done_a);
            end else begin
                cur_a = exp_a.pop_front();
                if (cur_a.cyc != cyc || cur_a.rd_en !== rd_en_a || cur_a.ch !== ch_sel_a[0]
                    || cur_a.dn !== done_a || busy_a !== 1'b1) begin
                    n_bad++;
                    $display("FAIL mon_a: got cyc=%0d rd_en=%b ch=%0d done=%b busy=%b, expected cyc=%0d rd_en=%b ch=%0d done=%b busy=1",
                             cyc, rd_en_a, ch_sel_a, done_a, busy_a,
                             cur_a.cyc, cur_a.rd_en, cur_a.ch, cur_a.dn);
                end
            end
        end
    end

    // Monitor for dut_b.
    always @(negedge clk) begin
        if (rd_en_b != 1'b0 || done_b) begin
            n_cmp++;
            if (exp_b.size() == 0) begin
                n_bad++;
                $display("FAIL mon_b unexpected: cyc=%0d rd_en=%b done=%b, expected no activity",
                         cyc, rd_en_b, done_b);
            end else begin
                cur_b = exp_b.pop_front();
                if (cur_b.cyc != cyc || cur_b.rd_en[0] !== rd_en_b[0] || cur_b.ch !== ch_sel_b[0]
                    || cur_b.dn !== done_b) begin
                    n_bad++;
                    $display("FAIL mon_b: got cyc=%0d rd_en=%b ch=%0d done=%b, expected cyc=%0d rd_en=%b ch=%0d done=%b",
                             cyc, rd_en_b, ch_sel_b, done_b,
                             cur_b.cyc, cur_b.rd_en[0], cur_b.ch, cur_b.dn);
                end
            end
        end
    end

    initial begin
        int base;
        ev_t e;
        rst_n   = 1'b0;
        flag_a  = 1'b0;
        flag_b  = 1'b0;
        empty_a = 2'b00;
        empty_b = 1'b0;
        #12;
        chk("reset_rd_en_a", 32'(rd_en_a), 0);
        chk("reset_ch_sel_a", 32'(ch_sel_a), 0);
        chk("reset_busy_a", 32'(busy_a), 0);
        chk("reset_done_a", 32'(done_a), 0);
        chk("reset_overrun_a", 32'(ovr_a), 0);
        chk("reset_busy_b", 32'(busy_b), 0);
        wait_edge();
        rst_n = 1'b1;
        repeat (2) wait_edge();

        // Basic sequence: 4 reads ch0, 2 gap cycles, 4 reads ch1, done.
        base = cyc;
        flag_a = 1'b1;
        push_seq_a(base);
        wait_edge();
        flag_a = 1'b0;
        repeat (14) wait_edge();
        chk("basic_drained", 32'(exp_a.size()), 0);
        chk("basic_idle", 32'(busy_a), 0);

        // Stall: ch0 empty for 3 cycles mid-burst.
        rd0_cnt = 0;
        rd1_cnt = 0;
        wait_edge();
        base = cyc;
        flag_a = 1'b1;
        push_a(base + 1, 2'b01, 1'b0, 1'b0);
        push_a(base + 2, 2'b01, 1'b0, 1'b0);
        push_a(base + 6, 2'b01, 1'b0, 1'b0);
        push_a(base + 7, 2'b01, 1'b0, 1'b0);
        for (int i = 10; i <= 13; i++) push_a(base + i, 2'b10, 1'b1, 1'b0);
        push_a(base + 14, 2'b00, 1'b1, 1'b1);
        wait_edge();
        flag_a = 1'b0;
        repeat (2) wait_edge();
        empty_a = 2'b01;
        repeat (3) wait_edge();
        empty_a = 2'b00;
        repeat (12) wait_edge();
        chk("stall_drained", 32'(exp_a.size()), 0);
        chk("stall_rd0_total", 32'(rd0_cnt), 4);
        chk("stall_rd1_total", 32'(rd1_cnt), 4);

        // Reset after two ch0 reads: immediate clear, no resume.
        wait_edge();
        base = cyc;
        flag_a = 1'b1;
        push_a(base + 1, 2'b01, 1'b0, 1'b0);
        push_a(base + 2, 2'b01, 1'b0, 1'b0);
        wait_edge();
        flag_a = 1'b0;
        wait_edge();
        chk("pre_reset_busy", 32'(busy_a), 1);
        wait_edge();
        rst_n = 1'b0;
        #1;
        chk("rst_rd_en", 32'(rd_en_a), 0);
        chk("rst_ch_sel", 32'(ch_sel_a), 0);
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_done", 32'(done_a), 0);
        chk("rst_overrun", 32'(ovr_a), 0);
        repeat (2) wait_edge();
        rst_n = 1'b1;
        repeat (12) wait_edge();
        chk("rst_no_resume_busy", 32'(busy_a), 0);
        chk("rst_drained", 32'(exp_a.size()), 0);

        // Retrigger during ch1 burst: ignored, 8 reads, overrun depends on build.
        rd0_cnt = 0;
        rd1_cnt = 0;
        wait_edge();
        base = cyc;
        flag_a = 1'b1;
        push_seq_a(base);
        wait_edge();
        flag_a = 1'b0;
        while (cyc < base + 8) wait_edge();
        flag_a = 1'b1;
        wait_edge();
        flag_a = 1'b0;
        repeat (10) wait_edge();
        chk("retrig_drained", 32'(exp_a.size()), 0);
        chk("retrig_total_reads", 32'(rd0_cnt + rd1_cnt), 8);
        chk("retrig_overrun", 32'(ovr_a), 32'(OVR_EXP));

        // flag_cols held high: back-to-back sequences, one IDLE cycle after done.
        wait_edge();
        base = cyc;
        flag_a = 1'b1;
        push_seq_a(base);
        push_seq_a(base + 12);
        while (cyc < base + 24) wait_edge();
        flag_a = 1'b0;
        repeat (14) wait_edge();
        chk("held_drained", 32'(exp_a.size()), 0);
        chk("held_idle", 32'(busy_a), 0);

        // Single channel, 552-word burst, no gap.
        wait_edge();
        base = cyc;
        flag_b = 1'b1;
        for (int i = 1; i <= 552; i++) begin
            e.cyc = base + i; e.rd_en = 2'b01; e.ch = 1'b0; e.dn = 1'b0;
            exp_b.push_back(e);
        end
        e.cyc = base + 553; e.rd_en = 2'b00; e.ch = 1'b0; e.dn = 1'b1;
        exp_b.push_back(e);
        wait_edge();
        flag_b = 1'b0;
        repeat (560) wait_edge();
        chk("long_drained", 32'(exp_b.size()), 0);
        chk("long_idle", 32'(busy_b), 0);
        chk("long_overrun", 32'(ovr_b), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_rd_scheduler.md
FIFO_RD_SCHEDULER -- requirements
Module: fifo_rd_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 2, meaning the number of FIFO channels drained per trigger.
REQ-002 The block SHALL have parameter BURST_LEN, default 552, meaning the number of words read from each channel per trigger.
REQ-003 The block SHALL have parameter GAP_CYC, default 0, meaning the idle cycles inserted between consecutive channel bursts.
REQ-004 The block SHALL have parameter CNT_W, default 10, meaning the counter width; BURST_LEN and GAP_CYC SHALL each be less than 2^CNT_W.
REQ-005 The block SHALL have port fifo_rd_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 The block SHALL have port flag_cols, input, 1 bit: level trigger; a column block is ready to drain.
REQ-008 The block SHALL have port fifo_empty, input, NUM_CH bits: per-channel FIFO empty flags.
REQ-009 The block SHALL have port fifo_rd_en, output, NUM_CH bits: per-channel read enable, at most one bit high.
REQ-010 The block SHALL have port ch_sel, output, $clog2(NUM_CH) bits (minimum 1): index of the channel being drained.
REQ-011 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle pulse when the last channel burst completes.
REQ-013 The block SHALL have port overrun, output, 1 bit: sticky trigger-while-busy flag (see Configuration).

Function
REQ-014 The block SHALL implement the states IDLE, READ, GAP and DONE.
REQ-015 IDLE -> READ SHALL occur on a clock edge with flag_cols=1; that edge loads ch_sel=0 and word counter=BURST_LEN.
REQ-016 In READ, fifo_rd_en[ch_sel] SHALL equal !fifo_empty[ch_sel], driven combinationally from registered state; all other bits SHALL be 0.
REQ-017 The word counter SHALL decrement only on cycles where fifo_rd_en[ch_sel]=1; empty cycles stall without loss, so exactly BURST_LEN reads are issued per channel.
REQ-018 When a read occurs with counter=1: if ch_sel<NUM_CH-1, the next state SHALL be GAP (or READ directly when GAP_CYC=0) with ch_sel+1 and counter reloaded; otherwise the next state SHALL be DONE.
REQ-019 GAP SHALL last exactly GAP_CYC cycles with fifo_rd_en all zero, then return to READ.
REQ-020 DONE SHALL last one cycle with done=1 and SHALL return to IDLE; a flag_cols still high in IDLE starts a new sequence on the following edge.
REQ-021 flag_cols SHALL be ignored in READ, GAP and DONE (no restart, no counter reload).
REQ-022 First-read latency SHALL be 1 cycle: fifo_rd_en rises in the cycle after the edge that samples flag_cols=1.
REQ-023 Counter arithmetic SHALL be unsigned CNT_W bits and SHALL never wrap below 1 in READ.

Reset
REQ-024 rst_n=0 SHALL immediately force state=IDLE, fifo_rd_en=0, ch_sel=0, busy=0, done=0, overrun=0 and counters=0, regardless of the clock.
REQ-025 Reset asserted mid-burst SHALL abort the sequence; after release the block SHALL wait in IDLE for flag_cols and SHALL NOT resume.
REQ-026 The deassertion of rst_n SHALL be synchronous to fifo_rd_clk (external synchroniser); no trigger SHALL be accepted on the release edge.

Configuration
REQ-027 With macro FIFO_RD_OVERRUN_EN defined, overrun SHALL be set when a rising edge of flag_cols (registered compare) occurs while busy=1, and SHALL clear only on reset.
REQ-028 Without FIFO_RD_OVERRUN_EN, overrun SHALL be tied to 0 and no edge-detect register SHALL be synthesised; all other behaviour is unchanged.

Verification
REQ-029 NUM_CH=2, BURST_LEN=4, GAP_CYC=2, FIFOs never empty, flag_cols pulse -> rd_en[0] high for 4 cycles, 2 zero cycles, rd_en[1] high for 4 cycles, done pulse 1 cycle later.
REQ-030 Same config, fifo_empty[0]=1 for 3 cycles in mid-burst -> rd_en[0] low for those 3 cycles; the total rd_en[0] count remains 4.
REQ-031 Same config, rst_n=0 after 2 reads on ch0 -> all outputs 0 at once; after release with flag_cols=0, the block stays idle and issues no reads.
REQ-032 flag_cols rising again during ch1 burst -> no restart, 8 total reads; overrun=1 with FIFO_RD_OVERRUN_EN defined, overrun=0 without it.
REQ-033 flag_cols held high continuously -> back-to-back sequences with exactly one IDLE cycle between the done pulse and the next rd_en[0].
REQ-034 NUM_CH=1, BURST_LEN=552, GAP_CYC=0 -> a single 552-cycle rd_en[0] burst, with ch_sel=0 throughout.
